// File: rtl/seq_div_display_pkg.sv
// Shared definitions for the sequential divider display: FSM encoding,
// hex-to-segment table and the one-cold digit anode patterns.
package seq_div_display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Active-low segments, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Index 0 is the rightmost digit
    localparam logic [3:0] AN_PATTERN [4] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    localparam int ITERATIONS = 4;

endpackage

// File: rtl/seq_div_display_hex_to_seg.sv
// Combinational 4-bit to active-low seven-segment decoder, shared by the
// lab display designs.
module hex_to_seg
    import seq_div_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seq_div_display.sv
// 4-bit unsigned restoring divider driven from switches, with operands and
// results shown on a time-multiplexed 4-digit seven-segment display.
module seq_div_display
    import seq_div_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic [7:0] sw,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy,
    output logic       div_zero
);

    localparam int CNT_W = REFRESH_BITS + 2;

    logic             sync_p0, sync_p1, sync_p2;
    logic             start_pulse;
    state_t           state, state_next;
    logic [3:0]       op_a, op_b, quo, rem;
    logic [4:0]       p;
    logic [3:0]       q;
    logic [1:0]       count;
    logic [4:0]       p_shift, p_next;
    logic             p_ge;
    logic [3:0]       q_next;
    logic [CNT_W-1:0] refresh_cnt;
    logic [1:0]       digit_sel;
    logic [3:0]       digit_nibble;
    logic [6:0]       digit_seg;

    // Button synchronizer and rising-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= btn_start;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign start_pulse = sync_p1 & ~sync_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_pulse && sw[3:0] != 4'd0) state_next = RUN;
            RUN:  if (count == 2'(ITERATIONS - 1))    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        p_shift = {p[3:0], q[3]};
        p_ge    = (p_shift >= {1'b0, op_b});
        p_next  = p_ge ? (p_shift - {1'b0, op_b}) : p_shift;
        q_next  = {q[2:0], p_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a     <= 4'd0;
            op_b     <= 4'd0;
            quo      <= 4'd0;
            rem      <= 4'd0;
            p        <= 5'd0;
            q        <= 4'd0;
            count    <= 2'd0;
            div_zero <= 1'b0;
        end else if (state == IDLE && start_pulse) begin
            op_a <= sw[7:4];
            op_b <= sw[3:0];
            if (sw[3:0] == 4'd0) begin
                quo      <= 4'hF;
                rem      <= sw[7:4];
                div_zero <= 1'b1;
            end else begin
                p        <= 5'd0;
                q        <= sw[7:4];
                count    <= 2'd0;
                div_zero <= 1'b0;
            end
        end else if (state == RUN) begin
            p     <= p_next;
            q     <= q_next;
            count <= count + 2'd1;
            if (count == 2'(ITERATIONS - 1)) begin
                quo <= q_next;
                rem <= p_next[3:0];
            end
        end
    end

    // Display refresh: top two counter bits pick the digit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) refresh_cnt <= '0;
        else     refresh_cnt <= refresh_cnt + CNT_W'(1);
    end

    assign digit_sel = refresh_cnt[CNT_W-1 -: 2];

    always_comb begin
        digit_nibble = rem;
        case (digit_sel)
            2'd0: digit_nibble = rem;
            2'd1: digit_nibble = quo;
            2'd2: digit_nibble = op_b;
            2'd3: digit_nibble = op_a;
            default: digit_nibble = rem;
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nibble (digit_nibble),
        .seg    (digit_seg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= AN_PATTERN[0];
            seg <= SEG_TABLE[0];
        end else begin
            an  <= AN_PATTERN[digit_sel];
            seg <= digit_seg;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seq_div_display.sv
// Scoreboard bench for seq_div_display: stimulus queues expected results,
// a monitor reads them back off the multiplexed display.
module tb_seq_div_display;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic [7:0] sw;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;
    logic       div_zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    logic mon_active = 1'b0;

    always #5 clk = ~clk;

    seq_div_display #(.REFRESH_BITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_start (btn_start),
        .sw        (sw),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .busy      (busy),
        .div_zero  (div_zero)
    );

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [3:0] exp_an(input int d);
        case (d)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Collect the segment code shown on each of the four digits
    task automatic scan_display(output logic [27:0] codes, output logic [3:0] seen);
        codes = '0;
        seen  = 4'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin codes[6:0]   = seg; seen[0] = 1'b1; end
                4'b1101: begin codes[13:7]  = seg; seen[1] = 1'b1; end
                4'b1011: begin codes[20:14] = seg; seen[2] = 1'b1; end
                4'b0111: begin codes[27:21] = seg; seen[3] = 1'b1; end
                default: ;
            endcase
        end
    endtask

    // Monitor: a result appears when busy falls or div_zero rises
    initial begin
        logic        pb;
        logic        pdz;
        exp_t        e;
        logic [27:0] got;
        logic [3:0]  seen;
        pb  = 1'b0;
        pdz = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ((pb && !busy) || (!pdz && div_zero))) begin
                mon_active = 1'b1;
                if (sb.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
                    scan_display(got, seen);
                    check("digits_seen", {28'd0, seen}, 32'hF);
                    check("digit_rem", {25'd0, got[6:0]},   {25'd0, exp_seg(e.r)});
                    check("digit_quo", {25'd0, got[13:7]},  {25'd0, exp_seg(e.q)});
                    check("digit_opb", {25'd0, got[20:14]}, {25'd0, exp_seg(e.b)});
                    check("digit_opa", {25'd0, got[27:21]}, {25'd0, exp_seg(e.a)});
                end
                mon_active = 1'b0;
            end
            pb  = busy;
            pdz = div_zero;
        end
    end

    // Press start (held `hold` cycles, or a 1-0-1 double tap), measure busy
    task automatic do_op(input logic [7:0] s, input int hold, input bit dbl,
                         input logic [3:0] q, input logic [3:0] r, input logic dz,
                         input logic [7:0] sw_mid, input int mid_at);
        exp_t e;
        int   busy_cycles;
        int   busy_rises;
        logic prev;
        int   n;
        busy_cycles = 0;
        busy_rises  = 0;
        prev        = 1'b0;
        e.a = s[7:4]; e.b = s[3:0]; e.q = q; e.r = r; e.dz = dz;
        sb.push_back(e);
        sw = s;
        n  = hold + 14;
        for (int i = 0; i < n; i++) begin
            btn_start = dbl ? (i == 0 || i == 2) : (i < hold);
            if (i == mid_at) sw = sw_mid;
            @(negedge clk);
            if (busy) busy_cycles++;
            if (busy && !prev) busy_rises++;
            prev = busy;
        end
        btn_start = 1'b0;
        check("busy_cycles", busy_cycles, dz ? 0 : 4);
        check("busy_windows", busy_rises, dz ? 0 : 1);
        for (int i = 0; i < 80 && (sb.size() != 0 || mon_active); i++) @(negedge clk);
        if (sb.size() != 0 || mon_active) check("monitor_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        logic [27:0] got;
        logic [3:0]  seen;
        int          k;
        rst       = 1'b1;
        btn_start = 1'b0;
        sw        = 8'h00;
        #3;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);
        check("rst_an", {28'd0, an}, 32'b1110);
        check("rst_seg", {25'd0, seg}, 32'b1000000);
        check("rst_dp", {31'd0, dp}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_op(8'hD4, 1, 1'b0, 4'h3, 4'h1, 1'b0, 8'hD4, -1);
        do_op(8'hF1, 1, 1'b0, 4'hF, 4'h0, 1'b0, 8'hF1, -1);
        do_op(8'h37, 1, 1'b0, 4'h0, 4'h3, 1'b0, 8'h37, -1);
        do_op(8'hFE, 1, 1'b0, 4'h1, 4'h1, 1'b0, 8'hFE, -1);
        do_op(8'h90, 1, 1'b0, 4'hF, 4'h9, 1'b1, 8'h90, -1);
        do_op(8'h62, 1, 1'b0, 4'h3, 4'h0, 1'b0, 8'h62, -1);
        do_op(8'hA3, 100, 1'b0, 4'h3, 4'h1, 1'b0, 8'h11, 5);
        do_op(8'hB5, 3, 1'b1, 4'h2, 4'h1, 1'b0, 8'hB5, -1);
        do_op(8'h2F, 1, 1'b0, 4'h0, 4'h2, 1'b0, 8'h2F, -1);

        // Abort a run with reset two cycles into it
        @(negedge clk);
        sw        = 8'hD4;
        btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        k = 0;
        while (!busy && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("abort_busy_seen", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_an", {28'd0, an}, 32'b1110);
        check("abort_seg", {25'd0, seg}, 32'b1000000);
        check("abort_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Refresh sequence from a fresh counter, all registers zero
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("refresh_an", {28'd0, an}, {28'd0, exp_an(((i - 1) >> 2) % 4)});
            check("refresh_seg", {25'd0, seg}, {25'd0, exp_seg(4'h0)});
        end
        check("abort_busy_after", {31'd0, busy}, 32'd0);

        scan_display(got, seen);
        check("abort_digits", {4'd0, got}, {4'd0, exp_seg(4'h0), exp_seg(4'h0), exp_seg(4'h0), exp_seg(4'h0)});

        do_op(8'h77, 1, 1'b0, 4'h1, 4'h0, 1'b0, 8'h77, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_div_display.md
# seq_div_display

Sequential 4-bit unsigned restoring divider for the switch/seven-segment lab board: the inverse operation of the combinational 2×2 multiplier display. Dividend and divisor come from switches. A start button launches one division. Dividend, divisor, quotient and remainder are shown as hex digits on the time-multiplexed 4-digit seven-segment display.

## Interface
- REFRESH_BITS, default 17: log2 of the cycles each digit stays lit; simulation uses 2.
- clk  in  1  system clock, 100 MHz on board
- rst  in  1  reset; asynchronous, active-high; one clock domain only
- btn_start  in  1  raw start push-button, asynchronous to clk
- sw  in  8  sw[7:4] = dividend, sw[3:0] = divisor; sampled only at start
- an  out  4  digit anodes, active-low; an[0] = rightmost digit
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
- dp  out  1  decimal point, active-low; constant 1 (off)
- busy  out  1  high while a division iterates
- div_zero  out  1  last started operation had divisor 0; sticky until next start

## Operation
- Start path: btn_start passes through a 2-FF synchronizer. start_pulse = sync & ~sync_d, so it is one cycle per press, and holding the button gives one pulse.
- FSM states are IDLE and RUN.
- IDLE with start_pulse, divisor ≠ 0:
  - latch A = sw[7:4] and B = sw[3:0] into operand registers
  - clear partial remainder P (5 bits) and the quotient shift register Q = A
  - set iteration count to 0 and go to RUN
- IDLE with start_pulse, divisor = 0:
  - latch operands
  - write quo = 4'hF, rem = A, div_zero = 1
  - stay IDLE; busy never rises
- Any start_pulse that is not a divide-by-zero clears div_zero.
- RUN iteration, one per cycle, 4 total:
  - P' = {P[3:0], Q[3]}; Q shifts left
  - if P' ≥ {1'b0,B}: P = P' − B and Q[0] = 1; else P = P' and Q[0] = 0
  - width rule: P stays 5 bits, the compare is 5-bit unsigned, B is zero-extended
- On the 4th iteration: write quo = final Q and rem = P[3:0], then return to IDLE.
- start_pulse in RUN is ignored and not queued.
- Result registers (opA, opB, quo, rem) hold until the next start.
- Display: a free-running counter of REFRESH_BITS+2 bits. Top 2 bits select the digit:
  - 0: rem, an = 1110
  - 1: quo, an = 1101
  - 2: opB, an = 1011
  - 3: opA, an = 0111
- Hex decode of the selected nibble: 0 → 1000000 … F → 0001110.

## Timing
- Reset values (asynchronous, immediate):
  - FSM = IDLE; all operand and result registers and the counter = 0
  - busy = 0, div_zero = 0, an = 1110, seg = 1000000, dp = 1
- Synchronizer adds 2 cycles from the btn_start edge to start_pulse.
- start_pulse high in cycle T:
  - busy = 1 in cycles T+1 … T+4
  - quo/rem valid from T+5
  - busy = 0 in T+5
  - a new start is accepted from T+5
- Divide-by-zero: quo, rem and div_zero update in T+1; busy stays 0.
- rst during RUN aborts immediately. No result is written; all outputs return to reset values.
- The display counter wraps from all-ones to 0; the digit sequence is 0,1,2,3,0,…
- an and seg are registered, updated on the same edge, so they are glitch-free.

## Structure
- Shared package/header holds:
  - the 16-entry hex→segment constant table
  - FSM state encoding: IDLE = 1'b0, RUN = 1'b1
  - anode one-cold patterns
- Sub-module hex_to_seg: combinational 4-bit → 7-bit active-low decoder, reusable by other lab displays.
- Top module contains the synchronizer, FSM and datapath, result registers and display mux.

## Test plan
- rst, sw = 8'hD4, press start → busy exactly 4 cycles; quo = 3, rem = 1, div_zero = 0; digits 1,3,4,D.
- sw = 8'hF1 → quo = F, rem = 0; sw = 8'h37 → quo = 0, rem = 3.
- sw = 8'h90 → busy stays 0; next cycle after start_pulse quo = F, rem = 9, div_zero = 1; following start with sw = 8'h62 clears div_zero and gives quo = 3, rem = 0.
- Hold btn_start 100 cycles, then change sw mid-run → exactly one busy window; results use the operands latched at start; a second pulse during busy is ignored.
- Assert rst at T+2 of a run → busy = 0, quo = rem = 0, an = 1110, seg = 1000000 immediately.
- REFRESH_BITS = 2 → an steps 1110 → 1101 → 1011 → 0111 every 4 cycles and wraps; seg matches the nibble shown on each digit.
